// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : parametrised raster timing generator with pixel enable,
//                  configurable sync polarity and delay-matched decode outputs.
// Revision 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int PIPE_DELAY = 0,
  parameter int FRAME_W    = 8,
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic [HW-1:0]      px,
  output logic [VW-1:0]      py,
  output logic               visible,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic          HP       = (H_POL != 0);
  localparam logic          VP       = (V_POL != 0);

  // Bit positions inside one decoded sample carried down the delay line.
  localparam int D_VIS = 0;
  localparam int D_HS  = 1;
  localparam int D_VS  = 2;
  localparam int D_LS  = 3;
  localparam int D_FS  = 4;

  typedef logic [4:0] dec_t;

  generate
    if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        PIPE_DELAY < 0 || PIPE_DELAY > 4 || FRAME_W < 1) begin : g_bad_params
      $error("vga_timing_gen: illegal parameter combination");
    end
  endgenerate

  logic [HW-1:0]      px_q, px_d;
  logic [VW-1:0]      py_q, py_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  dec_t               dec_now;
  dec_t               dec_out;

  always_comb begin
    px_d        = px_q;
    py_d        = py_q;
    frame_cnt_d = frame_cnt_q;
    if (ce) begin
      if (px_q == H_LAST) begin
        px_d = '0;
        if (py_q == V_LAST) begin
          py_d        = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end else begin
          py_d = py_q + 1'b1;
        end
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q        <= '0;
      py_q        <= '0;
      frame_cnt_q <= '0;
    end else begin
      px_q        <= px_d;
      py_q        <= py_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    dec_now        = '0;
    dec_now[D_VIS] = (px_q < H_VIS) && (py_q < V_VIS);
    dec_now[D_HS]  = (px_q >= HS_FIRST) && (px_q <= HS_LAST);
    dec_now[D_VS]  = (py_q >= VS_FIRST) && (py_q <= VS_LAST);
    dec_now[D_LS]  = (px_q == '0);
    dec_now[D_FS]  = (px_q == '0) && (py_q == '0);
  end

  generate
    if (PIPE_DELAY == 0) begin : g_direct
      // Counters sit at (0,0) during reset; mask so outputs show inactive levels.
      assign dec_out = rst_n ? dec_now : '0;
    end else begin : g_pipe
      dec_t pipe_q [PIPE_DELAY];
      dec_t pipe_d [PIPE_DELAY];

      always_comb begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          pipe_d[i] = pipe_q[i];
        end
        if (ce) begin
          pipe_d[0] = dec_now;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign dec_out = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  assign px          = px_q;
  assign py          = py_q;
  assign frame_cnt   = frame_cnt_q;
  assign visible     = dec_out[D_VIS];
  assign hsync       = dec_out[D_HS] ? HP : ~HP;
  assign vsync       = dec_out[D_VS] ? VP : ~VP;
  assign line_start  = dec_out[D_LS];
  assign frame_start = dec_out[D_FS];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// Directed bench for vga_timing_gen: four instances (default, short-frame,
// pipelined, tiny active-high) run in lockstep from a shared clock/reset/ce.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Default 640x480 mode
  logic [9:0] d_px, d_py; logic d_vis, d_hs, d_vs, d_ls, d_fs; logic [7:0] d_fc;
  // Default horizontal, 8-line frame (V 4/1/2/1)
  logic [9:0] m_px; logic [2:0] m_py; logic m_vis, m_hs, m_vs, m_ls, m_fs; logic [7:0] m_fc;
  // Default mode with PIPE_DELAY=2
  logic [9:0] p_px, p_py; logic p_vis, p_hs, p_vs, p_ls, p_fs; logic [7:0] p_fc;
  // Tiny mode H 4/1/2/1, V 3/1/1/1, active-high, FRAME_W=2
  logic [2:0] s_px, s_py; logic s_vis, s_hs, s_vs, s_ls, s_fs; logic [1:0] s_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .ce(ce), .px(d_px), .py(d_py), .visible(d_vis),
    .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc));

  vga_timing_gen #(.V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_med (
    .clk(clk), .rst_n(rst_n), .ce(ce), .px(m_px), .py(m_py), .visible(m_vis),
    .hsync(m_hs), .vsync(m_vs), .line_start(m_ls), .frame_start(m_fs), .frame_cnt(m_fc));

  vga_timing_gen #(.PIPE_DELAY(2)) u_pipe (
    .clk(clk), .rst_n(rst_n), .ce(ce), .px(p_px), .py(p_py), .visible(p_vis),
    .hsync(p_hs), .vsync(p_vs), .line_start(p_ls), .frame_start(p_fs), .frame_cnt(p_fc));

  vga_timing_gen #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .H_POL(1), .V_POL(1), .FRAME_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .ce(ce), .px(s_px), .py(s_py), .visible(s_vis),
    .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ce = 1'b1; rst_n = 1'b0;
    tick(3);
    checks++; if (d_px !== 10'd0 || d_py !== 10'd0) begin failures++; $display("FAIL reset_pos px=%0d py=%0d want 0,0", d_px, d_py); end
    checks++; if ({d_vis, d_ls, d_fs} !== 3'b000) begin failures++; $display("FAIL reset_strobes vis/ls/fs=%b want 000", {d_vis, d_ls, d_fs}); end
    checks++; if ({d_hs, d_vs} !== 2'b11) begin failures++; $display("FAIL reset_sync_lowpol hs/vs=%b want 11", {d_hs, d_vs}); end
    checks++; if ({s_hs, s_vs} !== 2'b00) begin failures++; $display("FAIL reset_sync_highpol hs/vs=%b want 00", {s_hs, s_vs}); end
    checks++; if (d_fc !== 8'd0) begin failures++; $display("FAIL reset_fc got=%0d want 0", d_fc); end
    rst_n = 1'b1;
    #1;
    checks++; if ({d_vis, d_ls, d_fs} !== 3'b111) begin failures++; $display("FAIL release_decode vis/ls/fs=%b want 111", {d_vis, d_ls, d_fs}); end
    checks++; if ({p_vis, p_ls, p_hs} !== 3'b001) begin failures++; $display("FAIL release_pipe vis/ls/hs=%b want 001", {p_vis, p_ls, p_hs}); end
  endtask

  task automatic test_pipe_startup;
    tick(1);
    checks++; if (p_px !== 10'd1) begin failures++; $display("FAIL pipe_t1_px got=%0d want 1", p_px); end
    checks++; if ({p_vis, p_ls, p_fs, p_hs, p_vs} !== 5'b00011) begin failures++; $display("FAIL pipe_t1_inactive got=%b want 00011", {p_vis, p_ls, p_fs, p_hs, p_vs}); end
    tick(1);
    checks++; if ({p_vis, p_ls, p_fs} !== 3'b111) begin failures++; $display("FAIL pipe_t2_decode got=%b want 111", {p_vis, p_ls, p_fs}); end
  endtask

  task automatic test_line;
    int hs_n = 0, hs_min = 9999, hs_max = -1, vis_n = 0, ls_n = 0;
    int phs_min = 9999, phs_max = -1, pvis_n = 0, pvis_max = -1, pls_px = -1;
    tick(798);
    checks++; if (d_px !== 10'd0 || d_py !== 10'd1) begin failures++; $display("FAIL line_entry px=%0d py=%0d want 0,1", d_px, d_py); end
    for (int i = 0; i < 800; i++) begin
      if (!d_hs) begin hs_n++; if (int'(d_px) < hs_min) hs_min = int'(d_px); if (int'(d_px) > hs_max) hs_max = int'(d_px); end
      if (d_vis) vis_n++;
      if (d_ls) ls_n++;
      if (!p_hs) begin if (int'(p_px) < phs_min) phs_min = int'(p_px); if (int'(p_px) > phs_max) phs_max = int'(p_px); end
      if (p_vis) begin pvis_n++; if (int'(p_px) > pvis_max) pvis_max = int'(p_px); end
      if (p_ls) pls_px = int'(p_px);
      tick(1);
    end
    checks++; if (hs_n != 96 || hs_min != 656 || hs_max != 751) begin failures++; $display("FAIL hsync_window n=%0d min=%0d max=%0d want 96 656 751", hs_n, hs_min, hs_max); end
    checks++; if (vis_n != 640) begin failures++; $display("FAIL line_visible got=%0d want 640", vis_n); end
    checks++; if (ls_n != 1) begin failures++; $display("FAIL line_start_count got=%0d want 1", ls_n); end
    checks++; if (d_px !== 10'd0 || d_py !== 10'd2) begin failures++; $display("FAIL line_period px=%0d py=%0d want 0,2", d_px, d_py); end
    checks++; if (phs_min != 658 || phs_max != 753) begin failures++; $display("FAIL pipe_hsync min=%0d max=%0d want 658 753", phs_min, phs_max); end
    checks++; if (pvis_n != 640 || pvis_max != 641) begin failures++; $display("FAIL pipe_visible n=%0d last=%0d want 640 641", pvis_n, pvis_max); end
    checks++; if (pls_px != 2) begin failures++; $display("FAIL pipe_line_start px=%0d want 2", pls_px); end
  endtask

  task automatic test_frame;
    int vis_n = 0, fs_n = 0, vs_n = 0, vs_min = 99, vs_max = -1;
    tick(4800);
    checks++; if (m_px !== 10'd0 || m_py !== 3'd0 || m_fc !== 8'd1 || m_fs !== 1'b1) begin failures++; $display("FAIL frame_entry px=%0d py=%0d fc=%0d fs=%0d want 0 0 1 1", m_px, m_py, m_fc, m_fs); end
    for (int i = 0; i < 6400; i++) begin
      if (m_vis) vis_n++;
      if (m_fs) fs_n++;
      if (!m_vs) begin vs_n++; if (int'(m_py) < vs_min) vs_min = int'(m_py); if (int'(m_py) > vs_max) vs_max = int'(m_py); end
      tick(1);
    end
    checks++; if (vis_n != 2560) begin failures++; $display("FAIL frame_visible got=%0d want 2560", vis_n); end
    checks++; if (fs_n != 1) begin failures++; $display("FAIL frame_start_count got=%0d want 1", fs_n); end
    checks++; if (vs_n != 1600 || vs_min != 5 || vs_max != 6) begin failures++; $display("FAIL vsync_window n=%0d min=%0d max=%0d want 1600 5 6", vs_n, vs_min, vs_max); end
    checks++; if (m_px !== 10'd0 || m_py !== 3'd0 || m_fc !== 8'd2) begin failures++; $display("FAIL frame_period px=%0d py=%0d fc=%0d want 0 0 2", m_px, m_py, m_fc); end
  endtask

  task automatic test_ce_toggle;
    logic [63:0] prev, now;
    int hold_err = 0, ls_n = 0, fs_n = 0;
    for (int i = 0; i < 12800; i++) begin
      ce = (i % 2 == 0);
      prev = {m_px, m_py, m_vis, m_hs, m_vs, m_ls, m_fs, m_fc, p_px, p_vis, p_hs, p_ls, p_fs};
      tick(1);
      now = {m_px, m_py, m_vis, m_hs, m_vs, m_ls, m_fs, m_fc, p_px, p_vis, p_hs, p_ls, p_fs};
      if (!ce && now !== prev) hold_err++;
      if (m_ls) ls_n++;
      if (m_fs) fs_n++;
      if (i == 1599) begin
        checks++; if (m_px !== 10'd0 || m_py !== 3'd1) begin failures++; $display("FAIL ce_line_1600 px=%0d py=%0d want 0,1", m_px, m_py); end
      end
    end
    ce = 1'b1;
    checks++; if (hold_err != 0) begin failures++; $display("FAIL ce_hold changed_cycles=%0d want 0", hold_err); end
    checks++; if (ls_n != 16 || fs_n != 2) begin failures++; $display("FAIL ce_strobe_len ls=%0d fs=%0d want 16 2", ls_n, fs_n); end
    checks++; if (m_px !== 10'd0 || m_py !== 3'd0 || m_fc !== 8'd3) begin failures++; $display("FAIL ce_frame_12800 px=%0d py=%0d fc=%0d want 0 0 3", m_px, m_py, m_fc); end
  endtask

  task automatic test_reset_midframe;
    ce = 1'b1;
    tick(1900);
    checks++; if (m_px !== 10'd300 || m_py !== 3'd2 || m_fc !== 8'd3) begin failures++; $display("FAIL mid_pos px=%0d py=%0d fc=%0d want 300 2 3", m_px, m_py, m_fc); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (m_px !== 10'd0 || m_py !== 3'd0 || m_fc !== 8'd0) begin failures++; $display("FAIL async_reset_cnt px=%0d py=%0d fc=%0d want 0 0 0", m_px, m_py, m_fc); end
    checks++; if ({m_vis, m_ls, m_fs, m_hs, m_vs} !== 5'b00011) begin failures++; $display("FAIL async_reset_out got=%b want 00011", {m_vis, m_ls, m_fs, m_hs, m_vs}); end
    checks++; if ({p_vis, p_hs, s_hs, s_vs} !== 4'b0100) begin failures++; $display("FAIL async_reset_other got=%b want 0100", {p_vis, p_hs, s_hs, s_vs}); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checks++; if (m_px !== 10'd1 || m_py !== 3'd0 || s_px !== 3'd1) begin failures++; $display("FAIL release_first_ce mpx=%0d mpy=%0d spx=%0d want 1 0 1", m_px, m_py, s_px); end
  endtask

  task automatic test_small_mode;
    int exp_seq[4] = '{1, 2, 3, 0};
    int k = 0, last_i = -1, hs_n = 0, vs_n = 0, vis_n = 0;
    int hs_min = 99, hs_max = -1, vs_min = 99, vs_max = -1;
    checks++; if (s_fc !== 2'd0) begin failures++; $display("FAIL small_fc_start got=%0d want 0", s_fc); end
    for (int i = 0; i < 192; i++) begin
      tick(1);
      if (s_hs) begin hs_n++; if (int'(s_px) < hs_min) hs_min = int'(s_px); if (int'(s_px) > hs_max) hs_max = int'(s_px); end
      if (s_vs) begin vs_n++; if (int'(s_py) < vs_min) vs_min = int'(s_py); if (int'(s_py) > vs_max) vs_max = int'(s_py); end
      if (s_vis) vis_n++;
      if (s_fs) begin
        checks++;
        if (k > 3 || int'(s_fc) != exp_seq[k & 3] || (k == 0 && i != 46) || (k > 0 && i - last_i != 48)) begin
          failures++; $display("FAIL small_frame_start k=%0d i=%0d fc=%0d", k, i, s_fc);
        end
        last_i = i; k++;
      end
    end
    checks++; if (k != 4) begin failures++; $display("FAIL small_fs_count got=%0d want 4", k); end
    checks++; if (hs_n != 48 || hs_min != 5 || hs_max != 6) begin failures++; $display("FAIL small_hsync n=%0d min=%0d max=%0d want 48 5 6", hs_n, hs_min, hs_max); end
    checks++; if (vs_n != 32 || vs_min != 4 || vs_max != 4) begin failures++; $display("FAIL small_vsync n=%0d min=%0d max=%0d want 32 4 4", vs_n, vs_min, vs_max); end
    checks++; if (vis_n != 48) begin failures++; $display("FAIL small_visible got=%0d want 48", vis_n); end
  endtask

  task automatic test_frame_wrap_hold;
    tick(46);
    checks++; if (s_px !== 3'd7 || s_py !== 3'd5 || s_fc !== 2'd0) begin failures++; $display("FAIL wrap_entry px=%0d py=%0d fc=%0d want 7 5 0", s_px, s_py, s_fc); end
    ce = 1'b0;
    tick(3);
    checks++; if (s_px !== 3'd7 || s_py !== 3'd5 || s_fc !== 2'd0 || s_fs !== 1'b0) begin failures++; $display("FAIL wrap_hold px=%0d py=%0d fc=%0d fs=%0d want 7 5 0 0", s_px, s_py, s_fc, s_fs); end
    ce = 1'b1;
    tick(1);
    checks++; if (s_px !== 3'd0 || s_py !== 3'd0 || s_fc !== 2'd1 || s_fs !== 1'b1) begin failures++; $display("FAIL wrap_resume px=%0d py=%0d fc=%0d fs=%0d want 0 0 1 1", s_px, s_py, s_fc, s_fs); end
  endtask

  initial begin
    test_reset;
    test_pipe_startup;
    test_line;
    test_frame;
    test_ce_toggle;
    test_reset_midframe;
    test_small_mode;
    test_frame_wrap_hold;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
